// File: rtl/operand_stage.sv
// Operand stage: issues register-file reads, then resolves EX/MEM forwarding and
// load-use stalls before handing operands downstream through a valid/ready register.
module operand_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        out_ready,
  input  logic [5:0]  in_rs,
  input  logic [5:0]  in_rt,
  input  logic [5:0]  in_rd,
  input  logic        in_ctrl_regwrt,
  input  logic        in_ctrl_memrd,
  output logic [5:0]  out_rs,
  output logic [5:0]  out_rt,
  input  logic [31:0] in_rsval,
  input  logic [31:0] in_rtval,
  input  logic        in_ex_regwrt,
  input  logic        in_ex_memrd,
  input  logic [5:0]  in_ex_rd,
  input  logic [31:0] in_ex_val,
  input  logic        in_mem_regwrt,
  input  logic [5:0]  in_mem_rd,
  input  logic [31:0] in_mem_val,
  input  logic        in_flush,
  output logic        out_valid,
  input  logic        in_ready,
  output logic [31:0] out_rsval,
  output logic [31:0] out_rtval,
  output logic [5:0]  out_rd,
  output logic        out_ctrl_regwrt,
  output logic        out_ctrl_memrd
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    EVAL = 2'd2
  } state_t;

  state_t      state_r;
  state_t      state_nxt_s;
  logic [5:0]  slot_rd_r;
  logic        slot_regwrt_r;
  logic        slot_memrd_r;
  logic        hazard_s;
  logic        advance_s;
  logic        accept_s;
  logic [31:0] fwd_rs_s;
  logic [31:0] fwd_rt_s;

  // EX wins over MEM; a load in EX never forwards (that case is the load-use stall).
  function automatic logic [31:0] fwd_sel(
    input logic [5:0]  idx,
    input logic [31:0] rf_val,
    input logic        ex_regwrt,
    input logic        ex_memrd,
    input logic [5:0]  ex_rd,
    input logic [31:0] ex_val,
    input logic        mem_regwrt,
    input logic [5:0]  mem_rd,
    input logic [31:0] mem_val
  );
    logic [31:0] res;
    if (ex_regwrt && !ex_memrd && (ex_rd == idx)) begin
      res = ex_val;
    end else if (mem_regwrt && (mem_rd == idx)) begin
      res = mem_val;
    end else begin
      res = rf_val;
    end
    return res;
  endfunction

  // Handshake qualifiers, forwarding muxes and next-state selection.
  always_comb begin
    hazard_s    = 1'b0;
    advance_s   = 1'b0;
    out_ready   = 1'b0;
    accept_s    = 1'b0;
    state_nxt_s = state_r;
    fwd_rs_s    = fwd_sel(out_rs, in_rsval, in_ex_regwrt, in_ex_memrd, in_ex_rd, in_ex_val,
                          in_mem_regwrt, in_mem_rd, in_mem_val);
    fwd_rt_s    = fwd_sel(out_rt, in_rtval, in_ex_regwrt, in_ex_memrd, in_ex_rd, in_ex_val,
                          in_mem_regwrt, in_mem_rd, in_mem_val);

    if (state_r == EVAL) begin
      hazard_s = in_ex_regwrt && in_ex_memrd && ((in_ex_rd == out_rs) || (in_ex_rd == out_rt));
    end else begin
      hazard_s = 1'b0;
    end

    advance_s = (state_r == EVAL) && !hazard_s && (!out_valid || in_ready);
    out_ready = (state_r == IDLE) || advance_s;
    accept_s  = in_valid && out_ready && !in_flush;

    if (in_flush) begin
      state_nxt_s = IDLE;
    end else begin
      case (state_r)
        IDLE:    state_nxt_s = accept_s ? READ : IDLE;
        READ:    state_nxt_s = EVAL;
        EVAL: begin
          if (advance_s) begin
            state_nxt_s = accept_s ? READ : IDLE;
          end else begin
            state_nxt_s = EVAL;
          end
        end
        default: state_nxt_s = IDLE;
      endcase
    end
  end

  // State, instruction slot and output register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r         <= IDLE;
      out_rs          <= 6'd0;
      out_rt          <= 6'd0;
      slot_rd_r       <= 6'd0;
      slot_regwrt_r   <= 1'b0;
      slot_memrd_r    <= 1'b0;
      out_valid       <= 1'b0;
      out_rsval       <= 32'd0;
      out_rtval       <= 32'd0;
      out_rd          <= 6'd0;
      out_ctrl_regwrt <= 1'b0;
      out_ctrl_memrd  <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      if (accept_s) begin
        out_rs        <= in_rs;
        out_rt        <= in_rt;
        slot_rd_r     <= in_rd;
        slot_regwrt_r <= in_ctrl_regwrt;
        slot_memrd_r  <= in_ctrl_memrd;
      end
      // Outputs only move on advance, so they hold while downstream stalls.
      if (in_flush) begin
        out_valid <= 1'b0;
      end else if (advance_s) begin
        out_valid       <= 1'b1;
        out_rsval       <= fwd_rs_s;
        out_rtval       <= fwd_rt_s;
        out_rd          <= slot_rd_r;
        out_ctrl_regwrt <= slot_regwrt_r;
        out_ctrl_memrd  <= slot_memrd_r;
      end else if (out_valid && in_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_operand_stage.sv
// Directed and randomized bench for operand_stage with a registered-read regfile model
// and a rule-level forwarding model.
module tb_operand_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        out_ready;
  logic [5:0]  in_rs, in_rt, in_rd;
  logic        in_ctrl_regwrt, in_ctrl_memrd;
  logic [5:0]  out_rs, out_rt;
  logic [31:0] in_rsval, in_rtval;
  logic        in_ex_regwrt, in_ex_memrd;
  logic [5:0]  in_ex_rd;
  logic [31:0] in_ex_val;
  logic        in_mem_regwrt;
  logic [5:0]  in_mem_rd;
  logic [31:0] in_mem_val;
  logic        in_flush;
  logic        out_valid;
  logic        in_ready;
  logic [31:0] out_rsval, out_rtval;
  logic [5:0]  out_rd;
  logic        out_ctrl_regwrt, out_ctrl_memrd;

  logic [31:0] rf [64];
  int          total = 0;
  int          passed = 0;

  operand_stage dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .out_ready(out_ready),
    .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd),
    .in_ctrl_regwrt(in_ctrl_regwrt), .in_ctrl_memrd(in_ctrl_memrd),
    .out_rs(out_rs), .out_rt(out_rt), .in_rsval(in_rsval), .in_rtval(in_rtval),
    .in_ex_regwrt(in_ex_regwrt), .in_ex_memrd(in_ex_memrd), .in_ex_rd(in_ex_rd),
    .in_ex_val(in_ex_val), .in_mem_regwrt(in_mem_regwrt), .in_mem_rd(in_mem_rd),
    .in_mem_val(in_mem_val), .in_flush(in_flush), .out_valid(out_valid),
    .in_ready(in_ready), .out_rsval(out_rsval), .out_rtval(out_rtval), .out_rd(out_rd),
    .out_ctrl_regwrt(out_ctrl_regwrt), .out_ctrl_memrd(out_ctrl_memrd)
  );

  always #5 clk = ~clk;

  // Register file with one-cycle registered read on the DUT's read addresses.
  always @(posedge clk) begin
    in_rsval <= rf[out_rs];
    in_rtval <= rf[out_rt];
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      $error("check %s", tag);
    end
  endtask

  task automatic set_fb(input logic exw, input logic exm, input logic [5:0] exd,
                        input logic [31:0] exv, input logic mw, input logic [5:0] md,
                        input logic [31:0] mv);
    in_ex_regwrt  = exw;
    in_ex_memrd   = exm;
    in_ex_rd      = exd;
    in_ex_val     = exv;
    in_mem_regwrt = mw;
    in_mem_rd     = md;
    in_mem_val    = mv;
  endtask

  task automatic drive_instr(input logic [5:0] rs, input logic [5:0] rt, input logic [5:0] rd,
                             input logic w, input logic m);
    in_valid       = 1'b1;
    in_rs          = rs;
    in_rt          = rt;
    in_rd          = rd;
    in_ctrl_regwrt = w;
    in_ctrl_memrd  = m;
  endtask

  // Expected operand from the forwarding rules: live EX result, then MEM, then regfile.
  function automatic logic [31:0] model_val(input logic [5:0] idx,
      input logic exw, input logic exm, input logic [5:0] exd, input logic [31:0] exv,
      input logic mw, input logic [5:0] md, input logic [31:0] mv);
    if (exw && !exm && exd == idx) return exv;
    if (mw && md == idx) return mv;
    return rf[idx];
  endfunction

  initial begin
    logic [5:0]  rs, rt, rd, exd, md;
    logic        w, m, exw, mw;
    logic [31:0] exv, mv, exp_rs, exp_rt;
    int          hz, bp;

    for (int i = 0; i < 64; i++) rf[i] = $urandom;
    rf[1] = 32'd8;
    rf[2] = 32'h100;
    rst = 1'b1; in_flush = 1'b0; in_ready = 1'b1;
    in_valid = 1'b0; in_rs = 6'd0; in_rt = 6'd0; in_rd = 6'd0;
    in_ctrl_regwrt = 1'b0; in_ctrl_memrd = 1'b0;
    set_fb(1'b0, 1'b0, 6'd0, 32'd0, 1'b0, 6'd0, 32'd0);
    tick(); tick();
    chk("rst_valid", out_valid, 32'd0);
    chk("rst_ready", out_ready, 32'd1);
    chk("rst_rs", out_rs, 32'd0);
    chk("rst_rsval", out_rsval, 32'd0);
    chk("rst_rd", out_rd, 32'd0);
    rst = 1'b0;

    // Plain read path, two-edge latency
    drive_instr(6'd1, 6'd2, 6'd3, 1'b1, 1'b0);
    #1 chk("plain_ready", out_ready, 32'd1);
    tick(); in_valid = 1'b0;
    chk("plain_addr", out_rs, 32'd1);
    chk("plain_e0_valid", out_valid, 32'd0);
    tick();
    chk("plain_e1_valid", out_valid, 32'd0);
    tick();
    chk("plain_valid", out_valid, 32'd1);
    chk("plain_rsval", out_rsval, 32'd8);
    chk("plain_rtval", out_rtval, 32'h100);
    chk("plain_rd", out_rd, 32'd3);
    chk("plain_ctrl", out_ctrl_regwrt, 32'd1);
    tick();
    chk("plain_consumed", out_valid, 32'd0);

    // Forwarding priority: EX over MEM, then MEM alone
    set_fb(1'b1, 1'b0, 6'd1, 32'h55, 1'b1, 6'd1, 32'h66);
    drive_instr(6'd1, 6'd2, 6'd4, 1'b0, 1'b1);
    tick(); in_valid = 1'b0; tick(); tick();
    chk("fwd_ex", out_rsval, 32'h55);
    chk("fwd_ex_rt", out_rtval, 32'h100);
    chk("fwd_memrd_ctrl", out_ctrl_memrd, 32'd1);
    tick();
    set_fb(1'b1, 1'b0, 6'd9, 32'h55, 1'b1, 6'd1, 32'h66);
    drive_instr(6'd1, 6'd2, 6'd4, 1'b0, 1'b0);
    tick(); in_valid = 1'b0; tick(); tick();
    chk("fwd_mem", out_rsval, 32'h66);
    tick();

    // Load-use stall for two EVAL cycles, then MEM forward on rt
    set_fb(1'b1, 1'b1, 6'd2, 32'h11, 1'b0, 6'd0, 32'd0);
    drive_instr(6'd1, 6'd2, 6'd5, 1'b1, 1'b0);
    tick(); in_valid = 1'b0; tick();
    chk("lu_ready0", out_ready, 32'd0);
    tick();
    chk("lu_valid0_a", out_valid, 32'd0);
    chk("lu_ready0_b", out_ready, 32'd0);
    tick();
    chk("lu_valid0_b", out_valid, 32'd0);
    set_fb(1'b0, 1'b0, 6'd0, 32'd0, 1'b1, 6'd2, 32'h77);
    #1 chk("lu_ready1", out_ready, 32'd1);
    tick();
    chk("lu_valid1", out_valid, 32'd1);
    chk("lu_rsval", out_rsval, 32'd8);
    chk("lu_rtval", out_rtval, 32'h77);
    tick();
    set_fb(1'b0, 1'b0, 6'd0, 32'd0, 1'b0, 6'd0, 32'd0);

    // Backpressure with a second instruction held in EVAL
    in_ready = 1'b0;
    drive_instr(6'd1, 6'd2, 6'd6, 1'b0, 1'b0);
    tick(); in_valid = 1'b0; tick();
    drive_instr(6'd2, 6'd1, 6'd7, 1'b1, 1'b0);
    #1 chk("bp_accept_b", out_ready, 32'd1);
    tick(); in_valid = 1'b0;
    chk("bp_a_valid", out_valid, 32'd1);
    chk("bp_a_rd", out_rd, 32'd6);
    tick(); tick();
    for (int k = 0; k < 3; k++) begin
      chk("bp_hold_ready", out_ready, 32'd0);
      chk("bp_hold_rd", out_rd, 32'd6);
      chk("bp_hold_rsval", out_rsval, 32'd8);
      chk("bp_hold_valid", out_valid, 32'd1);
      tick();
    end
    in_ready = 1'b1;
    #1 chk("bp_release_ready", out_ready, 32'd1);
    tick();
    chk("bp_b_valid", out_valid, 32'd1);
    chk("bp_b_rd", out_rd, 32'd7);
    chk("bp_b_rsval", out_rsval, 32'h100);
    chk("bp_b_rtval", out_rtval, 32'd8);
    tick();
    chk("bp_b_consumed", out_valid, 32'd0);

    // Reset in READ discards the instruction
    drive_instr(6'd1, 6'd2, 6'd8, 1'b1, 1'b1);
    tick(); in_valid = 1'b0;
    rst = 1'b1;
    tick(); rst = 1'b0;
    chk("rstr_valid", out_valid, 32'd0);
    chk("rstr_ready", out_ready, 32'd1);
    chk("rstr_rs", out_rs, 32'd0);
    chk("rstr_rd", out_rd, 32'd0);
    chk("rstr_rtval", out_rtval, 32'd0);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("rstr_no_stale", out_valid, 32'd0);
    end

    // Flush in READ: discarded, accept suppressed, read addresses retained
    drive_instr(6'd1, 6'd2, 6'd9, 1'b0, 1'b0);
    tick();
    in_flush = 1'b1;
    drive_instr(6'd5, 6'd6, 6'd10, 1'b0, 1'b0);
    tick(); in_flush = 1'b0; in_valid = 1'b0;
    chk("fl_valid", out_valid, 32'd0);
    chk("fl_ready", out_ready, 32'd1);
    chk("fl_rs_kept", out_rs, 32'd1);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("fl_no_stale", out_valid, 32'd0);
    end

    // Randomized single-instruction transactions with stalls and backpressure
    for (int n = 0; n < 40; n++) begin
      rs = 6'($urandom); rt = 6'($urandom); rd = 6'($urandom);
      w = 1'($urandom); m = 1'($urandom);
      hz = $urandom_range(0, 2); bp = $urandom_range(0, 3);
      exw = 1'($urandom); mw = 1'($urandom);
      exv = $urandom; mv = $urandom;
      case ($urandom_range(0, 2))
        0: exd = rs;
        1: exd = rt;
        default: exd = 6'($urandom);
      endcase
      case ($urandom_range(0, 2))
        0: md = rs;
        1: md = rt;
        default: md = 6'($urandom);
      endcase
      exp_rs = model_val(rs, exw, 1'b0, exd, exv, mw, md, mv);
      exp_rt = model_val(rt, exw, 1'b0, exd, exv, mw, md, mv);
      in_ready = 1'b1;
      if (hz > 0) set_fb(1'b1, 1'b1, ($urandom_range(0, 1) == 0) ? rs : rt, exv, mw, md, mv);
      else set_fb(exw, 1'b0, exd, exv, mw, md, mv);
      drive_instr(rs, rt, rd, w, m);
      #1 chk("rnd_accept_ready", out_ready, 32'd1);
      tick(); in_valid = 1'b0; tick();
      for (int k = 0; k < hz; k++) begin
        chk("rnd_hz_ready", out_ready, 32'd0);
        tick();
        chk("rnd_hz_valid", out_valid, 32'd0);
      end
      set_fb(exw, 1'b0, exd, exv, mw, md, mv);
      in_ready = (bp == 0);
      tick();
      chk("rnd_valid", out_valid, 32'd1);
      chk("rnd_rsval", out_rsval, exp_rs);
      chk("rnd_rtval", out_rtval, exp_rt);
      chk("rnd_rd", out_rd, {26'd0, rd});
      chk("rnd_ctrl", {out_ctrl_regwrt, out_ctrl_memrd}, {30'd0, w, m});
      for (int k = 0; k < bp; k++) begin
        tick();
        chk("rnd_bp_valid", out_valid, 32'd1);
        chk("rnd_bp_rsval", out_rsval, exp_rs);
      end
      in_ready = 1'b1;
      tick();
      chk("rnd_consumed", out_valid, 32'd0);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/operand_stage.md
OPERAND_STAGE -- requirements
Module: operand_stage

Interface
REQ-001 Parameters: none; register index width fixed at 6, data width fixed at 32.
REQ-002 One clock; reset is synchronous and active-high. Ports: clk  in  1  rising-edge clock; rst  in  1  synchronous active-high reset.
REQ-003 in_valid  in  1  upstream instruction valid; out_ready  out  1  stage accepts instruction this cycle.
REQ-004 in_rs, in_rt, in_rd  in  6 each  source/destination register indices.
REQ-005 in_ctrl_regwrt, in_ctrl_memrd  in  1 each  control bits carried with the instruction.
REQ-006 out_rs, out_rt  out  6 each  register-file read addresses (registered).
REQ-007 in_rsval, in_rtval  in  32 each  register-file read data (register file has one-cycle registered read latency).
REQ-008 in_ex_regwrt, in_ex_memrd  in  1; in_ex_rd  in  6; in_ex_val  in  32  EX-stage feedback.
REQ-009 in_mem_regwrt  in  1; in_mem_rd  in  6; in_mem_val  in  32  MEM-stage feedback.
REQ-010 in_flush  in  1  discard all held work.
REQ-011 out_valid  out  1; in_ready  in  1  downstream handshake; out_rsval, out_rtval  out  32; out_rd  out  6; out_ctrl_regwrt, out_ctrl_memrd  out  1.

Function
REQ-012 FSM states: IDLE, READ, EVAL.
REQ-013 out_ready SHALL be 1 in IDLE, or in EVAL when advance (REQ-018) holds; 0 otherwise.
REQ-014 Accept = in_valid && out_ready: latch in_rs/in_rt onto out_rs/out_rt, latch in_rd and control into slot, next state READ.
REQ-015 READ: unconditionally to EVAL next edge (regfile data for out_rs/out_rt valid during EVAL).
REQ-016 EVAL forwarding per operand X in {rs,rt}: if in_ex_regwrt && !in_ex_memrd && in_ex_rd==X use in_ex_val; else if in_mem_regwrt && in_mem_rd==X use in_mem_val; else in_rsval/in_rtval. EX priority over MEM. Register 0 not special-cased.
REQ-017 Load-use hazard in EVAL: in_ex_regwrt && in_ex_memrd && (in_ex_rd==out_rs || in_ex_rd==out_rt); stay in EVAL, no output load.
REQ-018 advance = EVAL && !hazard && (!out_valid || in_ready); on advance load out_rsval/out_rtval/out_rd/out_ctrl_*, set out_valid=1; next state READ if accept same edge else IDLE.
REQ-019 out_valid && in_ready with no advance: out_valid clears next edge. Outputs SHALL be stable while out_valid && !in_ready.
REQ-020 Latency: accept at edge E0 -> out_valid high after E2 (no hazard/backpressure); max throughput one instruction per 2 cycles.
REQ-021 in_flush (when rst=0): next state IDLE, out_valid=0, accept suppressed that cycle; out_rs/out_rt retain value.
REQ-022 Simultaneous hazard and backpressure: hazard wins; hold EVAL.

Reset
REQ-023 rst at any edge, including mid-READ/EVAL: state IDLE, out_valid=0, out_rs=out_rt=out_rd=0, out_rsval=out_rtval=0, out_ctrl_*=0; rst overrides in_flush and accept.
REQ-024 Held instruction discarded on reset; no output for it ever appears.

Verification
REQ-025 Plain: regfile r1=8, r2=0x100; accept rs=1, rt=2, rd=3, in_ready=1 -> after E2 out_valid=1, out_rsval=8, out_rtval=0x100, out_rd=3.
REQ-026 Forward: EVAL with in_ex_rd=1, in_ex_regwrt=1, in_ex_val=0x55 and in_mem_rd=1, in_mem_val=0x66 -> out_rsval=0x55; drop EX match -> 0x66.
REQ-027 Load-use: in_ex_memrd=1, in_ex_rd=2 for 2 cycles -> out_valid stays 0, out_ready=0; hazard clears -> out_valid 1 cycle later, value from regfile/MEM forward.
REQ-028 Backpressure: in_ready=0 with out_valid=1 for 3 cycles -> outputs unchanged, second instruction held in EVAL, out_ready=0; in_ready=1 -> both delivered in order.
REQ-029 Reset/flush mid-READ: rst (then separately in_flush) in READ -> next cycle state IDLE, out_valid=0, out_ready=1, no stale output.
